laser_cover: RTL and testbench
==============================

// Module: laser_cover
// PURPOSE
//  Laser-coverage optimiser. Takes 40 target points on a 16x16 grid, one per clock.
//  Searches for two circle centres (radius 4) that together cover as many points as possible.
//  A point is covered when (cx-px)^2+(cy-py)^2 <= 16 for C1 or for C2.
//  Standalone compute block: results are presented with a one-cycle DONE strobe.
// PARAMETERS
//  NPTS      40  points per pattern
//  MAX_PASS  6   maximum number of search passes per pattern
// PORTS
//  CLK   in   1  clock, all logic on rising edge
//  RST   in   1  synchronous active-high reset
//  X     in   4  point x coordinate (0..15)
//  Y     in   4  point y coordinate (0..15)
//  C1X   out  4  circle-1 centre x
//  C1Y   out  4  circle-1 centre y
//  C2X   out  4  circle-2 centre x
//  C2Y   out  4  circle-2 centre y
//  DONE  out  1  result-valid strobe
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (CLK, RST).
//  - Reset: C1X/C1Y/C2X/C2Y=0, DONE=0, state LOAD, point counter=0.
//  - States: LOAD -> SEARCH -> OUT -> LOAD.
//  - LOAD: X/Y sampled on every rising edge with RST low; edges 1..40 store points 0..39.
//  - After the 40th sample, go to SEARCH; further X/Y are ignored (may be X).
//  - SEARCH: one candidate centre per clock, scanned over index {y,x} from 0 to 255 (y-major).
//  - Coverage of a candidate is evaluated against all 40 points in parallel.
//    * |dx|,|dy| <= 15 (5-bit signed differences).
//    * Covered iff dx^2+dy^2 <= 16 (any equivalent LUT allowed).
//  - Per pass, one circle is varied while the other is held fixed.
//    * Score = union count (0..40, 6 bits).
//    * Best score is initialised to -1.
//    * Best is updated only on strictly greater score, so the earliest candidate wins ties.
//  - Pass 1: vary C1; C2 treated as covering nothing.
//  - Pass 2: vary C2 with C1 fixed.
//  - Passes 3+: alternate C1, C2.
//  - Stop after a pass >= 3 whose best union is not strictly greater than the previous pass total.
//    Also stop after MAX_PASS passes. When stopping, keep the prior centres.
//  - Each pass takes 256 cycles + <= 4 overhead cycles.
//  - Worst case is well under 50000 cycles per pattern.
//  - OUT: C1*/C2* hold the final centres; DONE=1 for exactly one cycle.
//  - The edge that clears DONE returns to LOAD with counter=0 and does not sample.
//  - The next 40 edges sample the next pattern; no reset occurs between patterns.
//  - C1*/C2* keep their values until overwritten by the next result.
//  - DONE never asserts in LOAD. DONE never X after reset.
//  - RST in any state aborts the current work and applies reset values on that edge.
// TESTING
//  - All 40 points at (5,5) -> DONE, C1=(5,1), C2=(0,0), cover 40.
//  - 20 points at (2,2) plus 20 at (12,12) -> C1=(0,0), C2=(12,8), cover 40.
//  - Two patterns back-to-back with no reset between them:
//    * DONE is high exactly 1 cycle.
//    * First point of pattern 2 is sampled on the 2nd edge after DONE rises.
//    * Both results are correct.
//  - RST pulsed mid-SEARCH -> outputs 0 and DONE 0 next edge; reload of 40 points gives the correct result.
//  - Random patterns (>= 6): cover count >= the greedy single-circle optimum.
//    DONE arrives within 50000 cycles of the last point.
//  - Points at corners (0,0), (15,15), (0,15), (15,0) only: no arithmetic wrap.
//    Each point is covered only when its true distance <= 4.

Source files
------------

// File: rtl/laser_cover.sv
// Two-circle (radius 4) coverage optimiser over 40 points on a 16x16 grid.
// Loads one point per clock, runs alternating exhaustive passes, then strobes DONE.
module laser_cover (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [3:0] C1X,
  output logic [3:0] C1Y,
  output logic [3:0] C2X,
  output logic [3:0] C2Y,
  output logic       DONE
);

  localparam int NPTS     = 40;
  localparam int MAX_PASS = 6;

  typedef enum logic [1:0] {S_LOAD, S_SEARCH, S_OUT} state_t;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [3:0]         px_q [NPTS];
  logic [3:0]         px_d [NPTS];
  logic [3:0]         py_q [NPTS];
  logic [3:0]         py_d [NPTS];
  logic [7:0]         cand_q, cand_d;
  logic [2:0]         pass_q, pass_d;
  logic signed [6:0]  best_q, best_d;
  logic [3:0]         bx_q, bx_d, by_q, by_d;
  logic [5:0]         prev_q, prev_d;
  logic [3:0]         w1x_q, w1x_d, w1y_q, w1y_d, w2x_q, w2x_d, w2y_q, w2y_d;
  logic [3:0]         c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;

  logic [3:0]         cand_x, cand_y, fix_x, fix_y;
  logic               vary_c1, fixed_en;
  logic [5:0]         score;
  logic               upd;
  logic [3:0]         bsx, bsy, nw1x, nw1y, nw2x, nw2y;
  logic signed [6:0]  bsc;
  logic [5:0]         fin;

  // Absolute differences are taken before squaring, so opposite corners never wrap.
  function automatic logic hit(input logic [3:0] cx, input logic [3:0] cy,
                               input logic [3:0] px, input logic [3:0] py);
    logic [3:0] ax, ay;
    logic [5:0] sum;
    ax  = (cx >= px) ? cx - px : px - cx;
    ay  = (cy >= py) ? cy - py : py - cy;
    sum = {3'b000, ax[2:0]} * {3'b000, ax[2:0]} + {3'b000, ay[2:0]} * {3'b000, ay[2:0]};
    return (ax <= 4'd4) && (ay <= 4'd4) && (sum <= 6'd16);
  endfunction

  assign cand_x   = cand_q[3:0];
  assign cand_y   = cand_q[7:4];
  assign vary_c1  = pass_q[0];
  assign fixed_en = (pass_q != 3'd1);
  assign fix_x    = vary_c1 ? w2x_q : w1x_q;
  assign fix_y    = vary_c1 ? w2y_q : w1y_q;

  always_comb begin
    score = '0;
    for (int i = 0; i < NPTS; i++) begin
      if (hit(cand_x, cand_y, px_q[i], py_q[i]) ||
          (fixed_en && hit(fix_x, fix_y, px_q[i], py_q[i])))
        score = score + 6'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    px_d    = px_q;
    py_d    = py_q;
    cand_d  = cand_q;
    pass_d  = pass_q;
    best_d  = best_q;
    bx_d    = bx_q;
    by_d    = by_q;
    prev_d  = prev_q;
    w1x_d   = w1x_q;
    w1y_d   = w1y_q;
    w2x_d   = w2x_q;
    w2y_d   = w2y_q;
    c1x_d   = c1x_q;
    c1y_d   = c1y_q;
    c2x_d   = c2x_q;
    c2y_d   = c2y_q;
    upd     = 1'b0;
    bsx     = bx_q;
    bsy     = by_q;
    bsc     = best_q;
    fin     = '0;
    nw1x    = w1x_q;
    nw1y    = w1y_q;
    nw2x    = w2x_q;
    nw2y    = w2y_q;

    case (state_q)
      S_LOAD: begin
        px_d[cnt_q] = X;
        py_d[cnt_q] = Y;
        if (cnt_q == 6'(NPTS - 1)) begin
          state_d = S_SEARCH;
          cnt_d   = '0;
          cand_d  = '0;
          pass_d  = 3'd1;
          best_d  = -7'sd1;
          prev_d  = '0;
          w1x_d   = '0;
          w1y_d   = '0;
          w2x_d   = '0;
          w2y_d   = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_SEARCH: begin
        upd    = $signed({1'b0, score}) > best_q;
        bsx    = upd ? cand_x : bx_q;
        bsy    = upd ? cand_y : by_q;
        bsc    = upd ? $signed({1'b0, score}) : best_q;
        best_d = bsc;
        bx_d   = bsx;
        by_d   = bsy;
        cand_d = cand_q + 8'd1;
        // Pass-end bookkeeping folds into the last candidate's cycle.
        if (cand_q == 8'hFF) begin
          fin = bsc[5:0];
          if (pass_q >= 3'd3 && fin <= prev_q) begin
            state_d = S_OUT;
            c1x_d   = w1x_q;
            c1y_d   = w1y_q;
            c2x_d   = w2x_q;
            c2y_d   = w2y_q;
          end else begin
            nw1x   = vary_c1 ? bsx : w1x_q;
            nw1y   = vary_c1 ? bsy : w1y_q;
            nw2x   = vary_c1 ? w2x_q : bsx;
            nw2y   = vary_c1 ? w2y_q : bsy;
            w1x_d  = nw1x;
            w1y_d  = nw1y;
            w2x_d  = nw2x;
            w2y_d  = nw2y;
            prev_d = fin;
            if (pass_q == 3'(MAX_PASS)) begin
              state_d = S_OUT;
              c1x_d   = nw1x;
              c1y_d   = nw1y;
              c2x_d   = nw2x;
              c2y_d   = nw2y;
            end else begin
              pass_d = pass_q + 3'd1;
              best_d = -7'sd1;
            end
          end
        end
      end

      S_OUT: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      cand_q  <= '0;
      pass_q  <= 3'd1;
      best_q  <= -7'sd1;
      bx_q    <= '0;
      by_q    <= '0;
      prev_q  <= '0;
      w1x_q   <= '0;
      w1y_q   <= '0;
      w2x_q   <= '0;
      w2y_q   <= '0;
      c1x_q   <= '0;
      c1y_q   <= '0;
      c2x_q   <= '0;
      c2y_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      pass_q  <= pass_d;
      best_q  <= best_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      prev_q  <= prev_d;
      w1x_q   <= w1x_d;
      w1y_q   <= w1y_d;
      w2x_q   <= w2x_d;
      w2y_q   <= w2y_d;
      c1x_q   <= c1x_d;
      c1y_q   <= c1y_d;
      c2x_q   <= c2x_d;
      c2y_q   <= c2y_d;
    end
  end

  always_ff @(posedge CLK) begin
    px_q <= px_d;
    py_q <= py_d;
  end

  assign C1X  = c1x_q;
  assign C1Y  = c1y_q;
  assign C2X  = c2x_q;
  assign C2Y  = c2y_q;
  assign DONE = (state_q == S_OUT);

endmodule

// File: tb/tb_laser_cover.sv
// Directed and random scenarios for laser_cover; every result is checked against
// hand-computed centres or an independent pass-by-pass model of the search.
module tb_laser_cover;

  logic       CLK;
  logic       RST;
  logic [3:0] X, Y;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic       DONE;

  int total;
  int bad;
  int pat_x [40];
  int pat_y [40];

  laser_cover dut (
    .CLK (CLK),
    .RST (RST),
    .X   (X),
    .Y   (Y),
    .C1X (C1X),
    .C1Y (C1Y),
    .C2X (C2X),
    .C2Y (C2Y),
    .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit dist_ok(int cx, int cy, int px, int py);
    return ((cx - px) * (cx - px) + (cy - py) * (cy - py)) <= 16;
  endfunction

  function automatic int cover_of(int c1x, int c1y, int c2x, int c2y);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++)
      if (dist_ok(c1x, c1y, pat_x[i], pat_y[i]) || dist_ok(c2x, c2y, pat_x[i], pat_y[i])) n++;
    return n;
  endfunction

  // Straight transcription of the pass schedule: best-of-256 per pass, strict improvement.
  task automatic model_run(output logic [15:0] exp_c, output int greedy);
    int c1x, c1y, c2x, c2y, prev, best, bx, by, u, fx, fy;
    bit v1;
    c1x = 0; c1y = 0; c2x = 0; c2y = 0; prev = 0; greedy = 0;
    for (int p = 1; p <= 6; p++) begin
      v1 = (p % 2) == 1;
      fx = v1 ? c2x : c1x;
      fy = v1 ? c2y : c1y;
      best = -1; bx = 0; by = 0;
      for (int idx = 0; idx < 256; idx++) begin
        u = 0;
        for (int i = 0; i < 40; i++)
          if (dist_ok(idx % 16, idx / 16, pat_x[i], pat_y[i]) ||
              (p > 1 && dist_ok(fx, fy, pat_x[i], pat_y[i]))) u++;
        if (u > best) begin best = u; bx = idx % 16; by = idx / 16; end
      end
      if (p == 1) greedy = best;
      if (p >= 3 && best <= prev) break;
      if (v1) begin c1x = bx; c1y = by; end
      else begin c2x = bx; c2y = by; end
      prev = best;
    end
    exp_c = {4'(c1x), 4'(c1y), 4'(c2x), 4'(c2y)};
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 40; i++) begin
      X = 4'(pat_x[i]);
      Y = 4'(pat_y[i]);
      @(posedge CLK); #1;
      if (i == 20) begin
        total++;
        if (DONE !== 1'b0) begin
          bad++;
          $display("FAIL done_in_load: DONE=%b required 0", DONE);
        end
      end
    end
  endtask

  task automatic wait_done(output bit seen);
    int n;
    n = 0;
    seen = 0;
    while (n < 50000) begin
      if (DONE === 1'b1) begin seen = 1; break; end
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; X = '0; Y = '0;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({C1X, C1Y, C2X, C2Y} !== 16'h0000) begin
      bad++;
      $display("FAIL reset_centres: got %h required 0000", {C1X, C1Y, C2X, C2Y});
    end
    total++;
    if (DONE !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: DONE=%b required 0", DONE);
    end
    RST = 1'b0;
  endtask

  task automatic test_single_cluster();
    bit seen;
    for (int i = 0; i < 40; i++) begin pat_x[i] = 5; pat_y[i] = 5; end
    load_pattern();
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL cluster_timeout: DONE not seen within 50000 cycles"); end
    total++;
    if ({C1X, C1Y, C2X, C2Y} !== 16'h5100) begin
      bad++;
      $display("FAIL cluster_centres: got %h required 5100", {C1X, C1Y, C2X, C2Y});
    end
    total++;
    if (cover_of(C1X, C1Y, C2X, C2Y) != 40) begin
      bad++;
      $display("FAIL cluster_cover: got %0d required 40", cover_of(C1X, C1Y, C2X, C2Y));
    end
    @(posedge CLK); #1;
    total++;
    if (DONE !== 1'b0) begin bad++; $display("FAIL cluster_done_width: DONE=%b required 0", DONE); end
  endtask

  task automatic test_corners();
    bit seen;
    for (int i = 0; i < 40; i++) begin
      pat_x[i] = (i % 4 == 1 || i % 4 == 3) ? 15 : 0;
      pat_y[i] = (i % 4 == 1 || i % 4 == 2) ? 15 : 0;
    end
    load_pattern();
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL corners_timeout: DONE not seen within 50000 cycles"); end
    total++;
    if ({C1X, C1Y, C2X, C2Y} !== 16'h00b0) begin
      bad++;
      $display("FAIL corners_centres: got %h required 00b0", {C1X, C1Y, C2X, C2Y});
    end
    total++;
    if (cover_of(C1X, C1Y, C2X, C2Y) != 20) begin
      bad++;
      $display("FAIL corners_cover: got %0d required 20", cover_of(C1X, C1Y, C2X, C2Y));
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    bit seen;
    for (int i = 0; i < 40; i++) begin
      pat_x[i] = (i < 20) ? 2 : 12;
      pat_y[i] = (i < 20) ? 2 : 12;
    end
    load_pattern();
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL b2b_first_timeout: DONE not seen within 50000 cycles"); end
    total++;
    if ({C1X, C1Y, C2X, C2Y} !== 16'h00c8) begin
      bad++;
      $display("FAIL b2b_first_centres: got %h required 00c8", {C1X, C1Y, C2X, C2Y});
    end
    // This edge must not sample; a stray (15,15) would move C2.
    X = 4'd15; Y = 4'd15;
    @(posedge CLK); #1;
    total++;
    if (DONE !== 1'b0) begin bad++; $display("FAIL b2b_done_width: DONE=%b required 0", DONE); end
    pat_x[0] = 0; pat_y[0] = 0;
    for (int i = 1; i < 40; i++) begin pat_x[i] = 5; pat_y[i] = 5; end
    load_pattern();
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL b2b_second_timeout: DONE not seen within 50000 cycles"); end
    total++;
    if ({C1X, C1Y, C2X, C2Y} !== 16'h3200) begin
      bad++;
      $display("FAIL b2b_second_centres: got %h required 3200", {C1X, C1Y, C2X, C2Y});
    end
    total++;
    if (cover_of(C1X, C1Y, C2X, C2Y) != 40) begin
      bad++;
      $display("FAIL b2b_second_cover: got %0d required 40", cover_of(C1X, C1Y, C2X, C2Y));
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid_search();
    bit seen;
    for (int i = 0; i < 40; i++) begin
      pat_x[i] = (i < 20) ? 2 : 12;
      pat_y[i] = (i < 20) ? 2 : 12;
    end
    load_pattern();
    repeat (100) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    total++;
    if ({C1X, C1Y, C2X, C2Y} !== 16'h0000 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h done=%b required 0000 done=0", {C1X, C1Y, C2X, C2Y}, DONE);
    end
    RST = 1'b0;
    for (int i = 0; i < 40; i++) begin pat_x[i] = 5; pat_y[i] = 5; end
    load_pattern();
    wait_done(seen);
    total++;
    if (!seen) begin bad++; $display("FAIL midreset_timeout: DONE not seen within 50000 cycles"); end
    total++;
    if ({C1X, C1Y, C2X, C2Y} !== 16'h5100) begin
      bad++;
      $display("FAIL midreset_centres: got %h required 5100", {C1X, C1Y, C2X, C2Y});
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    bit          seen;
    logic [15:0] exp_c;
    int          greedy, cov;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 40; i++) begin
        pat_x[i] = $urandom_range(0, 15);
        pat_y[i] = $urandom_range(0, 15);
      end
      model_run(exp_c, greedy);
      load_pattern();
      wait_done(seen);
      total++;
      if (!seen) begin bad++; $display("FAIL random%0d_timeout: DONE not seen within 50000 cycles", t); end
      cov = cover_of(C1X, C1Y, C2X, C2Y);
      total++;
      if (cov < greedy) begin
        bad++;
        $display("FAIL random%0d_cover: got %0d required >= %0d", t, cov, greedy);
      end
      total++;
      if ({C1X, C1Y, C2X, C2Y} !== exp_c) begin
        bad++;
        $display("FAIL random%0d_centres: got %h required %h", t, {C1X, C1Y, C2X, C2Y}, exp_c);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b1;
    X     = '0;
    Y     = '0;
    test_reset();
    test_single_cluster();
    test_corners();
    test_back_to_back();
    test_reset_mid_search();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
